// File: rtl/swap_unit_arbiter.sv
// Round-robin arbiter sharing one nibble-swap stage between two valid/ready
// requesters, with a one-entry output buffer and a drain counter.
module swap_unit_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              swap_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  done_count
);
    localparam int HALF = DATA_W / 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t        state_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_src_reg;
    logic              last_grant_reg;
    logic [CNT_W-1:0]  done_count_reg;

    logic              can_accept;
    logic              grant0;
    logic              grant1;
    logic              accept0;
    logic              accept1;
    logic              drain;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] swapped_data;
    logic [DATA_W-1:0] data_next;

    assign out_valid  = (state_reg == FULL);
    assign busy       = out_valid;
    assign out_data   = out_data_reg;
    assign out_src    = out_src_reg;
    assign done_count = done_count_reg;

    // A word may enter in the same cycle the held word leaves.
    assign can_accept = !out_valid || out_ready;

    // With both requesting, the one not served last wins.
    assign grant0 = req0_valid && (!req1_valid || last_grant_reg);
    assign grant1 = req1_valid && (!req0_valid || !last_grant_reg);

    // Readys are forced low while reset is asserted.
    assign req0_ready = grant0 && can_accept && !rst;
    assign req1_ready = grant1 && can_accept && !rst;

    assign accept0 = req0_valid && req0_ready;
    assign accept1 = req1_valid && req1_ready;
    assign drain   = out_valid && out_ready;

    assign sel_data = accept1 ? req1_data : req0_data;

    genvar gi;
    generate
        for (gi = 0; gi < HALF; gi++) begin : g_swap
            assign swapped_data[gi]        = sel_data[gi + HALF];
            assign swapped_data[gi + HALF] = sel_data[gi];
        end
    endgenerate

    assign data_next = swap_en ? swapped_data : sel_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= EMPTY;
            out_data_reg   <= '0;
            out_src_reg    <= 1'b0;
            last_grant_reg <= 1'b1;
            done_count_reg <= '0;
        end else begin
            if (drain) begin
                done_count_reg <= done_count_reg + 1'b1;
            end
            case (state_reg)
                EMPTY: begin
                    if (accept0 || accept1) begin
                        state_reg      <= FULL;
                        out_data_reg   <= data_next;
                        out_src_reg    <= accept1;
                        last_grant_reg <= accept1;
                    end
                end
                FULL: begin
                    if (accept0 || accept1) begin
                        out_data_reg   <= data_next;
                        out_src_reg    <= accept1;
                        last_grant_reg <= accept1;
                    end else if (drain) begin
                        state_reg <= EMPTY;
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end
endmodule
